// File: rtl/pll_drp_pkg.sv
// Shared constants for the PLL dynamic-reconfiguration controller:
// MD opcodes, response codes, FSM state encodings and register-count helper.
package pll_drp_pkg;

    localparam logic [1:0] MD_NOP = 2'b00;
    localparam logic [1:0] MD_WR  = 2'b01;
    localparam logic [1:0] MD_RD  = 2'b10;
    localparam logic [1:0] MD_LDA = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_CMD = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_VFY = 2'b11;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_CHK   = 4'd1;
    localparam state_t S_ADDR  = 4'd2;
    localparam state_t S_WR    = 4'd3;
    localparam state_t S_VADDR = 4'd4;
    localparam state_t S_VRD   = 4'd5;
    localparam state_t S_RST   = 4'd6;
    localparam state_t S_WLOCK = 4'd7;
    localparam state_t S_RESP  = 4'd8;

    // Number of 8-bit MD registers needed to hold one divider value.
    function automatic int calc_nb(input int div_w);
        return (div_w + 7) / 8;
    endfunction

endpackage

// File: rtl/pll_drp_ctrl_if.sv
// Command/response handshake between the clock-management CSR logic (master)
// and the PLL reconfiguration controller (slave).
interface pll_drp_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [DIV_W-1:0] cmd_div;
    logic             resp_valid;
    logic [1:0]       resp_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_div,
        input  cmd_ready, resp_valid, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_div,
        output cmd_ready, resp_valid, resp_err
    );
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the raw asynchronous PLL lock into clk.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_drp_ctrl.sv
// PLL runtime reconfiguration controller: writes per-channel dividers over the
// MD port, pulses PLL reset and waits for lock. Read-back verify: PLL_DRP_VERIFY_EN.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter int         DIV_W        = 8,
    parameter logic [7:0] BASE_ADDR    = 8'h10,
    parameter int         RST_HOLD_CYC = 16,
    parameter int         LOCK_TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    pll_drp_ctrl_if.slave  cmd,
    output logic           locked,
    output logic           lock_lost,
    output logic [1:0]     md_opc,
    output logic           md_ainc,
    output logic [7:0]     md_wdata,
    input  logic [7:0]     md_rdata,
    output logic           pll_rst,
    input  logic           pll_lock
);
    localparam int NB   = calc_nb(DIV_W);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t           state;
    logic [CH_W-1:0]  ch_q;
    logic [DIV_W-1:0] div_q;
    logic [31:0]      cnt;
    logic [1:0]       err_q;
    logic             locked_q;
    logic             accept;
    logic [7:0]       ch_addr;

    // Byte k of the divider, LSB first, upper bits of the last byte zero.
    function automatic logic [7:0] div_byte(input logic [DIV_W-1:0] div, input logic [31:0] k);
        logic [NB*8-1:0] padded;
        padded            = '0;
        padded[DIV_W-1:0] = div;
        return padded[k*8 +: 8];
    endfunction

    pll_lock_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (locked)
    );

    assign accept         = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.cmd_ready  = (state == S_IDLE);
    assign cmd.resp_valid = (state == S_RESP);
    assign cmd.resp_err   = err_q;
    assign pll_rst        = (state == S_RST);
    assign ch_addr        = 8'(32'(BASE_ADDR) + 32'(ch_q) * 32'(NB));

`ifdef PLL_DRP_VERIFY_EN
    logic vfy_bad;
    logic vfy_hit;
    // Read data lags the read opcode by one cycle, so cycle k checks byte k-1.
    assign vfy_hit = (state == S_VRD) && (cnt != 32'd0) && (md_rdata != div_byte(div_q, cnt - 32'd1));
`else
    logic unused_rdata;
    assign unused_rdata = ^md_rdata;
`endif

    always_comb begin
        md_opc   = MD_NOP;
        md_ainc  = 1'b0;
        md_wdata = 8'h00;
        case (state)
            S_ADDR: begin
                md_opc   = MD_LDA;
                md_wdata = ch_addr;
            end
            S_WR: begin
                md_opc   = MD_WR;
                md_ainc  = 1'b1;
                md_wdata = div_byte(div_q, cnt);
            end
`ifdef PLL_DRP_VERIFY_EN
            S_VADDR: begin
                md_opc   = MD_LDA;
                md_wdata = ch_addr;
            end
            S_VRD: begin
                if (cnt < 32'(NB)) begin
                    md_opc  = MD_RD;
                    md_ainc = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_q  <= cmd.cmd_ch;
            div_q <= cmd.cmd_div;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            err_q     <= ERR_OK;
            lock_lost <= 1'b0;
            locked_q  <= 1'b0;
`ifdef PLL_DRP_VERIFY_EN
            vfy_bad   <= 1'b0;
`endif
        end else begin
            locked_q <= locked;
            if (accept)
                lock_lost <= 1'b0;
            else if (state == S_IDLE && locked_q && !locked)
                lock_lost <= 1'b1;

            case (state)
                S_IDLE: if (accept) state <= S_CHK;
                S_CHK: begin
                    cnt <= '0;
                    if (32'(ch_q) >= 32'(NUM_CH) || div_q == '0) begin
                        err_q <= ERR_CMD;
                        state <= S_RESP;
                    end else begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    cnt   <= '0;
                    state <= S_WR;
                end
                S_WR: begin
                    if (cnt == 32'(NB - 1)) begin
                        cnt <= '0;
`ifdef PLL_DRP_VERIFY_EN
                        state <= S_VADDR;
`else
                        state <= S_RST;
`endif
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`ifdef PLL_DRP_VERIFY_EN
                S_VADDR: begin
                    cnt     <= '0;
                    vfy_bad <= 1'b0;
                    state   <= S_VRD;
                end
                S_VRD: begin
                    if (vfy_hit) vfy_bad <= 1'b1;
                    if (cnt == 32'(NB)) begin
                        cnt <= '0;
                        if (vfy_bad || vfy_hit) begin
                            err_q <= ERR_VFY;
                            state <= S_RESP;
                        end else begin
                            state <= S_RST;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                S_RST: begin
                    if (cnt == 32'(RST_HOLD_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_WLOCK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WLOCK: begin
                    // The first two cycles may still show a pre-reset lock.
                    if (locked && cnt >= 32'd2) begin
                        err_q <= ERR_OK;
                        state <= S_RESP;
                    end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
                        err_q <= ERR_TMO;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Self-checking bench for pll_drp_ctrl with MD register-file and PLL lock models.
module tb_pll_drp_ctrl;

    // NUM_CH=3 keeps the 2-bit channel field of a 4-channel build while making ch=3 out of range.
    localparam int NUM_CH  = 3;
    localparam int DIV_W   = 12;
    localparam int RST_HLD = 16;
    localparam int LOCK_TO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked, lock_lost;
    logic [1:0] md_opc;
    logic       md_ainc;
    logic [7:0] md_wdata;
    logic [7:0] md_rdata = 8'h00;
    logic       pll_rst;
    logic       pll_lock = 1'b1;

    pll_drp_ctrl_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    pll_drp_ctrl #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .BASE_ADDR(8'h10),
        .RST_HOLD_CYC(RST_HLD), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(bus.slave),
        .locked(locked), .lock_lost(lock_lost),
        .md_opc(md_opc), .md_ainc(md_ainc), .md_wdata(md_wdata), .md_rdata(md_rdata),
        .pll_rst(pll_rst), .pll_lock(pll_lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [11:0] div;
        bit          lock_never;
        bit          corrupt;
        logic [1:0]  err;
        int          rst_len;
        int          gap;
        bit          fast;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] md_exp[$];
    vec_t        resp_exp[$];
    vec_t        vecs[$];
    vec_t        mon_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // PLL model: lock drops while in reset, relocks 100 cycles after reset falls.
    bit lock_never = 1'b0;
    bit lock_drop  = 1'b0;
    int lock_cnt   = 0;
    always @(posedge clk) begin
        if (pll_rst) begin
            pll_lock <= 1'b0;
            lock_cnt <= 0;
        end else if (lock_drop) begin
            pll_lock <= 1'b0;
            lock_cnt <= 99;
        end else if (!pll_lock && !lock_never) begin
            if (lock_cnt == 99) pll_lock <= 1'b1;
            lock_cnt <= lock_cnt + 1;
        end
    end

    // MD register file model with optional corruption of one address on read.
    logic [7:0] mem [256];
    logic [7:0] md_addr = 8'h00;
    bit         corrupt = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;
    always @(posedge clk) begin
        case (md_opc)
            2'b11: md_addr <= md_wdata;
            2'b01: begin
                mem[md_addr] <= md_wdata;
                md_addr      <= md_addr + {7'd0, md_ainc};
            end
            2'b10: begin
                md_rdata <= mem[md_addr] ^ ((corrupt && md_addr == corrupt_addr) ? 8'hFF : 8'h00);
                md_addr  <= md_addr + {7'd0, md_ainc};
            end
            default: ;
        endcase
    end

    int rst_len = 0, gap = 0, lat = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                if (resp_exp.size() == 0) begin
                    check("resp_unexpected", resp_exp.size(), 1);
                end else begin
                    mon_v = resp_exp.pop_front();
                    check("resp_err", {30'd0, bus.resp_err}, {30'd0, mon_v.err});
                    check("pll_rst_len", rst_len, mon_v.rst_len);
                    if (mon_v.gap >= 0) check("lock_timeout_gap", gap, mon_v.gap);
                    if (mon_v.fast) check("bad_cmd_latency_le3", {31'd0, lat <= 3}, 1);
                end
            end
            if (md_opc != 2'b00)
                check("md_op", {21'd0, md_opc, md_ainc, md_wdata},
                      (md_exp.size() != 0) ? {21'd0, md_exp.pop_front()} : 32'hFFFF_FFFF);
            if (bus.cmd_valid && bus.cmd_ready) begin
                rst_len = 0; gap = 0; lat = 0;
            end else begin
                lat++;
                if (pll_rst) begin
                    rst_len++; gap = 0;
                end else begin
                    gap++;
                end
            end
        end
    end

    function automatic vec_t mk(logic [1:0] ch, logic [11:0] div, bit never, bit corr,
                                logic [1:0] err, int rl, int gp, bit fast);
        vec_t v;
        v.ch = ch; v.div = div; v.lock_never = never; v.corrupt = corr;
        v.err = err; v.rst_len = rl; v.gap = gp; v.fast = fast;
        return v;
    endfunction

    task automatic push_md(input logic [1:0] ch, input logic [11:0] div);
        logic [7:0] addr;
        addr = 8'h10 + {5'd0, ch, 1'b0};
        md_exp.push_back({2'b11, 1'b0, addr});
        md_exp.push_back({2'b01, 1'b1, div[7:0]});
        md_exp.push_back({2'b01, 1'b1, 4'h0, div[11:8]});
`ifdef PLL_DRP_VERIFY_EN
        md_exp.push_back({2'b11, 1'b0, addr});
        md_exp.push_back({2'b10, 1'b1, 8'h00});
        md_exp.push_back({2'b10, 1'b1, 8'h00});
`endif
    endtask

    task automatic send_cmd(input logic [1:0] ch, input logic [11:0] div);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_ch = ch; bus.cmd_div = div;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        check("cmd_accepted", {31'd0, acc}, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        got        = 1'b0;
        lock_never = v.lock_never;
        corrupt    = v.corrupt;
        corrupt_addr = 8'h10 + {5'd0, v.ch, 1'b0} + 8'd1;
        if (v.err != 2'b01) push_md(v.ch, v.div);
        resp_exp.push_back(v);
        send_cmd(v.ch, v.div);
        for (int i = 0; i < 1000; i++) begin
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("resp_seen", {31'd0, got}, 1);
        @(negedge clk);
        check("cmd_ready_after_resp", {31'd0, bus.cmd_ready}, 1);
        check("md_trace_complete", md_exp.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int nresp;
        bus.cmd_valid = 1'b0; bus.cmd_ch = '0; bus.cmd_div = '0;

        vecs.push_back(mk(2'd2, 12'hA5C, 0, 0, 2'b00, RST_HLD, -1, 0));
        vecs.push_back(mk(2'd0, 12'h001, 0, 0, 2'b00, RST_HLD, -1, 0));
        vecs.push_back(mk(2'd3, 12'h005, 0, 0, 2'b01, 0, -1, 1));
        vecs.push_back(mk(2'd1, 12'h000, 0, 0, 2'b01, 0, -1, 1));
        vecs.push_back(mk(2'd1, 12'hFFF, 1, 0, 2'b10, RST_HLD, LOCK_TO, 0));
        vecs.push_back(mk(2'd2, 12'h800, 0, 0, 2'b00, RST_HLD, -1, 0));
`ifdef PLL_DRP_VERIFY_EN
        vecs.push_back(mk(2'd2, 12'hA5C, 0, 1, 2'b11, 0, -1, 0));
        vecs.push_back(mk(2'd1, 12'h3C7, 0, 0, 2'b00, RST_HLD, -1, 0));
`endif

        repeat (3) @(negedge clk);
        check("rst_md_opc",     {30'd0, md_opc}, 0);
        check("rst_md_ainc",    {31'd0, md_ainc}, 0);
        check("rst_md_wdata",   {24'd0, md_wdata}, 0);
        check("rst_pll_rst",    {31'd0, pll_rst}, 0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 0);
        check("rst_resp_err",   {30'd0, bus.resp_err}, 0);
        check("rst_lock_lost",  {31'd0, lock_lost}, 0);
        check("rst_locked",     {31'd0, locked}, 0);
        check("rst_cmd_ready",  {31'd0, bus.cmd_ready}, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("locked_after_sync", {31'd0, locked}, 1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Single-cycle lock drop in IDLE sets lock_lost; the next command clears it.
        lock_never = 1'b0;
        corrupt    = 1'b0;
        repeat (120) @(negedge clk);
        check("lock_lost_pre", {31'd0, lock_lost}, 0);
        @(posedge clk); #1 lock_drop = 1'b1;
        @(posedge clk); #1 lock_drop = 1'b0;
        repeat (6) @(negedge clk);
        check("lock_lost_set", {31'd0, lock_lost}, 1);
        check("locked_restored", {31'd0, locked}, 1);
        run_vec(mk(2'd1, 12'h123, 0, 0, 2'b00, RST_HLD, -1, 0));
        check("lock_lost_cleared", {31'd0, lock_lost}, 0);

        // Reset asserted while pll_rst is high abandons the sequence silently.
        push_md(2'd0, 12'h003);
        send_cmd(2'd0, 12'h003);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pll_rst) begin
                got = 1'b1;
                break;
            end
        end
        check("pll_rst_reached", {31'd0, got}, 1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_pll_rst", {31'd0, pll_rst}, 0);
        check("midrst_md_opc",  {30'd0, md_opc}, 0);
        check("midrst_resp",    {31'd0, bus.resp_valid}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
        nresp = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) nresp++;
        end
        check("midrst_no_resp", nresp, 0);
        check("midrst_md_trace", md_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
